mem_arbiter: RTL
================

# mem_arbiter

Parametrised shared-memory arbiter and access sequencer that replaces the single hard-wired fetch/data path between the core and its 16-bit synchronous memory. It accepts byte, halfword and word requests from `N_PORTS` requesters (instruction fetch, load/store, debug/DMA). It picks one by round-robin or fixed priority and splits each request into one or two halfword beats on the memory bus. It returns assembled read data with a one-cycle acknowledge pulse.

## Interface
- `MEM_DEPTH`, 4096: memory depth in halfwords; localparam `ADDR_WIDTH` = clog2(MEM_DEPTH*2) (byte address).
- `N_PORTS`, 2: number of requesters, ≥1.
- `RR`, 1: 1 = round-robin arbitration, 0 = fixed priority (port 0 highest).

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `i_req`  in  N_PORTS  request per port; held with its fields until that port's `o_ack`.
- `i_we`  in  N_PORTS  1 = write.
- `i_size`  in  2*N_PORTS  per port: 00 byte, 01 halfword, 10 word, 11 treated as word.
- `i_addr`  in  N_PORTS*ADDR_WIDTH  byte address per port.
- `i_wdata`  in  32*N_PORTS  write data per port (byte in [7:0], half in [15:0]).
- `o_ack`  out  N_PORTS  one-cycle completion pulse to the granted port.
- `o_err`  out  1  valid with `o_ack`: request was misaligned, no memory access made.
- `o_rdata`  out  32  read data, valid only while `o_ack` is high; zero-extended for byte/half.
- `o_mem_addr`  out  ADDR_WIDTH-1  halfword index to memory.
- `o_mem_di`  out  16  write data; lane 0 = [7:0] (even byte), lane 1 = [15:8] (odd byte).
- `o_mem_en`  out  1  memory access strobe.
- `o_mem_rd_en`  out  1  read strobe.
- `o_mem_wr_en`  out  2  per-lane write enable.
- `i_mem_do`  in  16  memory read data, valid the cycle after a read beat.

## Operation
- States: IDLE, B0, B1, DONE.
- IDLE: if any `i_req`, register the grant index and latch that port's we/size/addr/wdata.
  - Aligned request → B0.
  - Misaligned request (half or word with addr[0]=1) → DONE with error flag.
- Round-robin: search starts at `last+1` modulo N_PORTS; `last` updates on every grant. Reset value of `last` = N_PORTS-1, so port 0 wins first. RR=0 always picks the lowest set index.
- B0: `o_mem_en`=1, `o_mem_addr`=addr[ADDR_WIDTH-1:1].
  - Read: `o_mem_rd_en`=1.
  - Write, byte: wr_en lane = addr[0]; the byte is replicated on both lanes.
  - Write, half: wr_en=11, `o_mem_di`=wdata[15:0].
  - Write, word: wr_en=11, `o_mem_di`=wdata[15:0].
  - Word → B1; otherwise → DONE.
- B1 (word only): address = B0 index + 1, wrapping modulo MEM_DEPTH.
  - Write: `o_mem_di`=wdata[31:16].
  - Read: capture `i_mem_do` (B0 data) into the low-half register.
  - → DONE.
- DONE: `o_ack[grant]`=1 and `o_err`=error flag; `o_mem_*` are all 0; → IDLE.
  - Read `o_rdata`:
    - byte: {24'b0, selected lane of `i_mem_do` per addr[0]}.
    - half: {16'b0, `i_mem_do`}.
    - word: {`i_mem_do`, low-half register}.
  - Write or error: `o_rdata`=0.
- Outside B0/B1, `o_mem_en`, `o_mem_rd_en`, `o_mem_wr_en` and `o_mem_di` are 0. Outside DONE, `o_ack`, `o_err` and `o_rdata` are 0.
- Requests from non-granted ports are ignored until the arbiter returns to IDLE. A port may drop `i_req` only after its ack; dropping it mid-access does not abort the access.

## Timing
- Reset: state IDLE; every output 0; `last`=N_PORTS-1. Reset during B0/B1/DONE aborts the access with no ack. A write beat already issued stays in memory.
- Request sampled in IDLE at cycle T:
  - Byte/half: B0 at T+1, ack at T+2.
  - Word: B0 at T+1, B1 at T+2, ack at T+3.
  - Error: ack+err at T+1.
- IDLE is re-entered at ack+1. A requester that still holds `i_req` at that cycle issues a new request.
- Throughput: one byte/half access per 3 cycles; one word per 4 cycles.
- Simultaneous requests: exactly one grant per IDLE cycle; no port starves under RR.

## Test plan
- **Half write/read, port 0:** write 0xBEEF at addr 0x010, then read it back → wr_en=11 at T+1; read ack at T+2 with `o_rdata`=0x0000BEEF.
- **Word write/read, port 1:** write 0x12345678 at 0x020 → beats at index 0x10 (0x5678) and 0x11 (0x1234); read back → ack at T+3 with 0x12345678.
- **Byte write/read:** write 0xAA at 0x031 → wr_en=10, `o_mem_di`=0xAAAA; byte read at 0x031 → 0x000000AA.
- **Contention with RR=1:** both ports hold `i_req` continuously → grants alternate 0,1,0,1. With RR=0 → port 0 is granted every time.
- **Misaligned and wrap:** half read at 0x005 → `o_ack`+`o_err` at T+1 and `o_mem_en` never high. Word at byte address MEM_DEPTH*2-2 → second beat at index 0.
- **Reset mid-access:** assert `rst` during B1 of a word read → no ack; outputs are 0 the next cycle; the next request completes normally.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and 16-bit memory bus bundle for mem_arbiter
interface mem_arbiter_if #(
    parameter int N_PORTS   = 2,
    parameter int MEM_DEPTH = 4096
);
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH * 2);

    logic [N_PORTS-1:0]            i_req;
    logic [N_PORTS-1:0]            i_we;
    logic [2*N_PORTS-1:0]          i_size;
    logic [N_PORTS*ADDR_WIDTH-1:0] i_addr;
    logic [32*N_PORTS-1:0]         i_wdata;
    logic [N_PORTS-1:0]            o_ack;
    logic                          o_err;
    logic [31:0]                   o_rdata;
    logic [ADDR_WIDTH-2:0]         o_mem_addr;
    logic [15:0]                   o_mem_di;
    logic                          o_mem_en;
    logic                          o_mem_rd_en;
    logic [1:0]                    o_mem_wr_en;
    logic [15:0]                   i_mem_do;

    modport slave (
        input  i_req, i_we, i_size, i_addr, i_wdata, i_mem_do,
        output o_ack, o_err, o_rdata, o_mem_addr, o_mem_di, o_mem_en, o_mem_rd_en, o_mem_wr_en
    );

    modport master (
        output i_req, i_we, i_size, i_addr, i_wdata, i_mem_do,
        input  o_ack, o_err, o_rdata, o_mem_addr, o_mem_di, o_mem_en, o_mem_rd_en, o_mem_wr_en
    );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - N-port arbiter splitting byte/half/word requests into halfword memory beats
module mem_arbiter #(
    parameter int MEM_DEPTH = 4096,
    parameter int N_PORTS   = 2,
    parameter int RR        = 1
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  bus
);
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH * 2);
    localparam int PW         = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
    localparam logic [ADDR_WIDTH-2:0] LAST_IDX  = (ADDR_WIDTH-1)'(MEM_DEPTH - 1);
    localparam logic [PW-1:0]         LAST_PORT = PW'(N_PORTS - 1);

    typedef enum logic [1:0] {IDLE, B0, B1, DONE} state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         grant_q, grant_d;
    logic [PW-1:0]         last_q, last_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic                  err_q, err_d;
    logic [15:0]           lo_q, lo_d;

    logic                  mem_en_q, mem_en_d;
    logic                  rd_en_q, rd_en_d;
    logic [1:0]            wr_en_q, wr_en_d;
    logic [15:0]           di_q, di_d;
    logic [ADDR_WIDTH-2:0] maddr_q, maddr_d;
    logic [N_PORTS-1:0]    ack_q, ack_d;
    logic                  err_out_q, err_out_d;

    logic [PW-1:0]         sel, cand;
    logic                  any_req;
    logic                  req_we;
    logic [1:0]            req_size;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  misaligned;
    logic [31:0]           rdata;

    // Round-robin scan begins just after the last winner; fixed priority scans from port 0.
    always_comb begin
        sel     = '0;
        cand    = '0;
        any_req = 1'b0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (RR != 0) begin
                if (int'(last_q) + 1 + i >= N_PORTS)
                    cand = PW'(int'(last_q) + 1 + i - N_PORTS);
                else
                    cand = PW'(int'(last_q) + 1 + i);
            end else begin
                cand = PW'(i);
            end
            if (!any_req && bus.i_req[cand]) begin
                any_req = 1'b1;
                sel     = cand;
            end
        end
    end

    always_comb begin
        req_we    = 1'b0;
        req_size  = '0;
        req_addr  = '0;
        req_wdata = '0;
        for (int p = 0; p < N_PORTS; p++) begin
            if (sel == PW'(p)) begin
                req_we    = bus.i_we[p];
                req_size  = bus.i_size[2*p +: 2];
                req_addr  = bus.i_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
                req_wdata = bus.i_wdata[32*p +: 32];
            end
        end
    end

    assign misaligned = req_addr[0] && (req_size != 2'b00);

    // Memory strobes are computed for the state being entered so they appear registered.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        we_d      = we_q;
        size_d    = size_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        lo_d      = lo_q;
        mem_en_d  = 1'b0;
        rd_en_d   = 1'b0;
        wr_en_d   = 2'b00;
        di_d      = '0;
        maddr_d   = '0;
        ack_d     = '0;
        err_out_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = sel;
                    last_d  = sel;
                    we_d    = req_we;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    err_d   = misaligned;
                    if (misaligned) begin
                        state_d    = DONE;
                        ack_d[sel] = 1'b1;
                        err_out_d  = 1'b1;
                    end else begin
                        state_d  = B0;
                        mem_en_d = 1'b1;
                        maddr_d  = req_addr[ADDR_WIDTH-1:1];
                        if (!req_we) begin
                            rd_en_d = 1'b1;
                        end else if (req_size == 2'b00) begin
                            wr_en_d = req_addr[0] ? 2'b10 : 2'b01;
                            di_d    = {2{req_wdata[7:0]}};
                        end else begin
                            wr_en_d = 2'b11;
                            di_d    = req_wdata[15:0];
                        end
                    end
                end
            end
            B0: begin
                if (size_q[1]) begin
                    state_d  = B1;
                    mem_en_d = 1'b1;
                    maddr_d  = (maddr_q == LAST_IDX) ? '0 : maddr_q + 1'b1;
                    if (we_q) begin
                        wr_en_d = 2'b11;
                        di_d    = wdata_q[31:16];
                    end else begin
                        rd_en_d = 1'b1;
                    end
                end else begin
                    state_d        = DONE;
                    ack_d[grant_q] = 1'b1;
                end
            end
            B1: begin
                lo_d           = bus.i_mem_do;
                state_d        = DONE;
                ack_d[grant_q] = 1'b1;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read data comes straight from the memory output during DONE.
    always_comb begin
        rdata = '0;
        if (state_q == DONE && !we_q && !err_q) begin
            if (size_q[1])
                rdata = {bus.i_mem_do, lo_q};
            else if (size_q[0])
                rdata = {16'h0000, bus.i_mem_do};
            else
                rdata = {24'h000000, addr_q[0] ? bus.i_mem_do[15:8] : bus.i_mem_do[7:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            last_q    <= LAST_PORT;
            we_q      <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            lo_q      <= '0;
            mem_en_q  <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 2'b00;
            di_q      <= '0;
            maddr_q   <= '0;
            ack_q     <= '0;
            err_out_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            we_q      <= we_d;
            size_q    <= size_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            lo_q      <= lo_d;
            mem_en_q  <= mem_en_d;
            rd_en_q   <= rd_en_d;
            wr_en_q   <= wr_en_d;
            di_q      <= di_d;
            maddr_q   <= maddr_d;
            ack_q     <= ack_d;
            err_out_q <= err_out_d;
        end
    end

    assign bus.o_ack       = ack_q;
    assign bus.o_err       = err_out_q;
    assign bus.o_rdata     = rdata;
    assign bus.o_mem_addr  = maddr_q;
    assign bus.o_mem_di    = di_q;
    assign bus.o_mem_en    = mem_en_q;
    assign bus.o_mem_rd_en = rd_en_q;
    assign bus.o_mem_wr_en = wr_en_q;
endmodule
